// File: rtl/adders_pkg.sv
// Shared definitions for the adder library.
//   nblk()       : number of carry-select blocks (= pipeline stages) for a width
//   stage_ctl_t  : per-stage control bundle (valid, block carry-out, overflow)
package adders_pkg;

   function automatic int nblk(input int width, input int block);
      return width / block;
   endfunction

   // The operand/partial-sum vectors depend on the top-level WIDTH, so they
   // live beside this bundle in each stage rather than inside it.
   typedef struct packed {
      logic valid;   // stage holds a live operation
      logic carry;   // carry out of this stage's block
      logic ovf;     // carry-into-MSB ^ carry-out; meaningful in the last stage only
   } stage_ctl_t;

endpackage

// File: rtl/csla_block.sv
// One carry-select block: two ripple chains (assumed carry-in 0 and 1)
// followed by a select mux driven by the real carry-in.
// Ports:
//   a, b      [BLOCK-1:0]  block operands
//   cin_sel                carry into the block, selects the candidate
//   sum       [BLOCK-1:0]  selected block sum
//   cout                   carry out of the block MSB
//   c_msb_in               carry into the block MSB (for signed overflow)
module csla_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin_sel,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [BLOCK:0]   c0_chain;
   logic [BLOCK:0]   c1_chain;
   logic [BLOCK-1:0] s0;
   logic [BLOCK-1:0] s1;

   always_comb begin
      c0_chain    = '0;
      c1_chain    = '0;
      s0          = '0;
      s1          = '0;
      c1_chain[0] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
         s0[i]         = a[i] ^ b[i] ^ c0_chain[i];
         c0_chain[i+1] = (a[i] & b[i]) | (c0_chain[i] & (a[i] ^ b[i]));
         s1[i]         = a[i] ^ b[i] ^ c1_chain[i];
         c1_chain[i+1] = (a[i] & b[i]) | (c1_chain[i] & (a[i] ^ b[i]));
      end
   end

   always_comb begin
      sum      = cin_sel ? s1 : s0;
      cout     = cin_sel ? c1_chain[BLOCK] : c0_chain[BLOCK];
      c_msb_in = cin_sel ? c1_chain[BLOCK-1] : c0_chain[BLOCK-1];
   end

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor. One stage per BLOCK bits; the
// inter-block carry is registered, so results come out NBLK cycles after
// acceptance at one per cycle. Stalls freeze the whole pipe.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     operand handshake (in_ready is combinational)
//   a, b [WIDTH-1:0]        operands
//   cin                     carry-in (add only)
//   sub                     1: a - b, 0: a + b + cin
//   out_valid / out_ready   result handshake
//   sum [WIDTH-1:0]         result, modulo 2^WIDTH
//   cout                    carry out of MSB (sub: 1 = no borrow)
//   ovf                     signed overflow
module csla_pipe
   import adders_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NBLK = nblk(WIDTH, BLOCK);

   if (WIDTH % BLOCK != 0) begin : g_param_err
      $error("csla_pipe: WIDTH must be a multiple of BLOCK");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Subtraction is a + ~b + 1.
   always_comb begin
      b_eff = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
   end

   for (genvar k = 0; k < NBLK; k++) begin : g_stage
      stage_ctl_t       ctl_d;
      stage_ctl_t       ctl_q;
      logic [WIDTH-1:0] a_d;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_d;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_q;

      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] sum_in;
      logic             v_in;
      logic             c_in;
      logic [BLOCK-1:0] blk_sum;
      logic             blk_cout;
      logic             blk_c_msb;

      if (k == 0) begin : g_src
         assign a_in   = a;
         assign b_in   = b_eff;
         assign sum_in = '0;
         assign v_in   = in_valid;
         assign c_in   = c0;
      end else begin : g_src
         assign a_in   = g_stage[k-1].a_q;
         assign b_in   = g_stage[k-1].b_q;
         assign sum_in = g_stage[k-1].sum_q;
         assign v_in   = g_stage[k-1].ctl_q.valid;
         assign c_in   = g_stage[k-1].ctl_q.carry;
      end

      csla_block #(.BLOCK(BLOCK)) u_blk (
         .a        (a_in[k*BLOCK +: BLOCK]),
         .b        (b_in[k*BLOCK +: BLOCK]),
         .cin_sel  (c_in),
         .sum      (blk_sum),
         .cout     (blk_cout),
         .c_msb_in (blk_c_msb)
      );

      // Lower bits come resolved from the previous stage; upper operand bits
      // ride along untouched until their own stage.
      always_comb begin
         ctl_d       = '0;
         ctl_d.valid = v_in;
         ctl_d.carry = blk_cout;
         ctl_d.ovf   = blk_cout ^ blk_c_msb;
         a_d         = a_in;
         b_d         = b_in;
         sum_d       = sum_in;
         sum_d[k*BLOCK +: BLOCK] = blk_sum;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ctl_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
         end else if (adv) begin
            ctl_q <= ctl_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
         end
      end
   end

   always_comb begin
      out_valid = g_stage[NBLK-1].ctl_q.valid;
      sum       = g_stage[NBLK-1].sum_q;
      cout      = g_stage[NBLK-1].ctl_q.carry;
      ovf       = g_stage[NBLK-1].ctl_q.ovf;
      adv       = !out_valid || out_ready;
      in_ready  = adv;
   end

endmodule

// File: tb/tb_csla_pipe.sv
module tb_csla_pipe;

   localparam int WIDTH = 16;
   localparam int BLOCK = 4;
   localparam int NBLK  = WIDTH / BLOCK;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              cin = 1'b0;
   logic              sub = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              ovf;

   csla_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                  input logic cc, input logic ss);
      exp_t e;
      int   ua, ub, sa, sb, ures, sres;
      ua = int'(aa);
      ub = int'(bb);
      sa = int'($signed(aa));
      sb = int'($signed(bb));
      if (ss) begin
         ures   = ua - ub;
         sres   = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         ures   = ua + ub + int'(cc);
         sres   = sa + sb + int'(cc);
         e.cout = (ures > 65535);
      end
      e.sum = ures[WIDTH-1:0];
      e.ovf = (sres > 32767) || (sres < -32768);
      return e;
   endfunction

   // Expected-result producer: an operand set seen valid&&ready here is
   // accepted at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready)
         exp_q.push_back(model(a, b, cin, sub));
   end

   // Output monitor.
   logic             held = 1'b0;
   logic [WIDTH-1:0] held_sum;
   logic             held_cout, held_ovf;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_sum", 32'(sum), 32'd0);
         check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         held = 1'b0;
      end else begin
         check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (held) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(held_sum));
            check("stall_flags", {30'd0, cout, ovf}, {30'd0, held_cout, held_ovf});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sum", 32'(sum), 32'(e.sum));
               check("cout", 32'(cout), 32'(e.cout));
               check("ovf", 32'(ovf), 32'(e.ovf));
            end
         end
         held      = out_valid && !out_ready;
         held_sum  = sum;
         held_cout = cout;
         held_ovf  = ovf;
      end
   end

   // Present one operand set (or an idle cycle when v=0) and hold it until accepted.
   task automatic drive(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic cc, input logic ss);
      logic acc;
      int   n;
      in_valid = v;
      a        = aa;
      b        = bb;
      cin      = cc;
      sub      = ss;
      n        = 0;
      do begin
         @(negedge clk);
         acc = in_ready || !v;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int lat;

      // 1. reset held with valid random operands
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      repeat (3) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 2-4. directed arithmetic corners
      drive(1, 16'h0003, 16'h0005, 0, 0);
      drive(1, 16'h0003, 16'h0005, 1, 0);
      drive(1, 16'hFFFF, 16'h0001, 0, 0);
      drive(1, 16'hFFFF, 16'h0001, 1, 0);
      drive(1, 16'h7FFF, 16'h0001, 0, 0);
      drive(1, 16'h0005, 16'h0007, 0, 1);
      drive(1, 16'h8000, 16'h0001, 0, 1);
      drive(1, 16'h0005, 16'h0007, 1, 1);
      drive(1, 16'h8000, 16'h0001, 1, 1);
      drain();

      // 5. back-to-back stream with a mid-stream stall
      fork
         begin
            for (int i = 0; i < 8; i++)
               drive(1, 16'(i), 16'(16'h0100 * i), 0, 0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // 6. reset with three operations in flight
      drive(1, 16'h1111, 16'h2222, 0, 0);
      drive(1, 16'h3333, 16'h4444, 1, 0);
      drive(1, 16'h5555, 16'h0001, 0, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("reset_drops_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // latency of a fresh operation after reset
      in_valid = 1'b1;
      a        = 16'h1234;
      b        = 16'h4321;
      cin      = 1'b0;
      sub      = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 32'(lat), 32'(NBLK));
      drain();

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++)
               drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                     1'($urandom), 1'($urandom));
         end
         begin
            for (int i = 0; i < 300; i++) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
